// File: rtl/redux_stack_pkg.sv
// Shared types for the REDUX-V data stack: per-cycle operation encoding
// and the decode from the raw push/pop strobes.
package redux_stack_pkg;

  typedef enum logic [1:0] {
    OP_NOP     = 2'd0,
    OP_PUSH    = 2'd1,
    OP_POP     = 2'd2,
    OP_REPLACE = 2'd3
  } stack_op_t;

  // Both strobes together mean "replace the top", not two separate ops.
  function automatic stack_op_t decode_op(input logic push, input logic pop);
    stack_op_t op;
    case ({push, pop})
      2'b10:   op = OP_PUSH;
      2'b01:   op = OP_POP;
      2'b11:   op = OP_REPLACE;
      default: op = OP_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/stack_ram.sv
// Stack storage: DEPTH x BITS array, one synchronous write port and one
// asynchronous read port. Contents are not reset.
module stack_ram #(
  parameter int BITS      = 8,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [BITS-1:0]      wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [BITS-1:0]      rdata
);

  logic [BITS-1:0] mem [2**ADDR_BITS];

  // Single write port, committed on the rising edge.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stack_mem.sv
// Data-side LIFO for the REDUX-V stack. Holds occupancy, the registered
// top-of-stack word and status flags; storage lives in stack_ram.
// Optional macro STACK_ERR_EN adds a sticky err output for overflow/underflow.
module stack_mem
  import redux_stack_pkg::*;
#(
  parameter int BITS      = 8,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [BITS-1:0]      din,
  output logic [BITS-1:0]      dout,
  output logic                 valid,
  output logic                 full,
  output logic                 empty,
  output logic [ADDR_BITS:0]   count
`ifdef STACK_ERR_EN
  ,
  output logic                 err
`endif
);

  localparam logic [ADDR_BITS:0]   CNT_ONE = (ADDR_BITS+1)'(1);
  localparam logic [ADDR_BITS:0]   CNT_TWO = (ADDR_BITS+1)'(2);
  localparam logic [ADDR_BITS-1:0] IDX_ONE = ADDR_BITS'(1);
  localparam logic [ADDR_BITS-1:0] IDX_TWO = ADDR_BITS'(2);

  stack_op_t             op;
  logic [ADDR_BITS:0]    count_nxt;
  logic [BITS-1:0]       dout_nxt;
  logic                  we;
  logic [ADDR_BITS-1:0]  waddr;
  logic [ADDR_BITS-1:0]  raddr;
  logic [BITS-1:0]       rdata;

  // Count never exceeds DEPTH, so its MSB alone marks the full state.
  assign full  = count[ADDR_BITS];
  assign empty = (count == '0);
  assign valid = !empty;

  // Look one entry below the top so a pop can load the new top directly.
  assign raddr = count[ADDR_BITS-1:0] - IDX_TWO;
  assign op    = decode_op(push, pop);

  stack_ram #(.BITS(BITS), .ADDR_BITS(ADDR_BITS)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (din),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Next count/top/write decode; illegal operations leave everything as is.
  always_comb begin
    count_nxt = count;
    dout_nxt  = dout;
    we        = 1'b0;
    waddr     = count[ADDR_BITS-1:0];
    case (op)
      OP_PUSH: begin
        if (!full) begin
          we        = 1'b1;
          count_nxt = count + CNT_ONE;
          dout_nxt  = din;
        end
      end
      OP_POP: begin
        if (count >= CNT_TWO) begin
          count_nxt = count - CNT_ONE;
          dout_nxt  = rdata;
        end else if (!empty) begin
          count_nxt = '0;
          dout_nxt  = '0;
        end
      end
      OP_REPLACE: begin
        // On an empty stack only the push half can take effect.
        we       = 1'b1;
        dout_nxt = din;
        if (!empty) begin
          waddr = count[ADDR_BITS-1:0] - IDX_ONE;
        end else begin
          count_nxt = CNT_ONE;
        end
      end
      default: ;
    endcase
  end

  // Occupancy and registered top-of-stack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      dout  <= '0;
    end else begin
      count <= count_nxt;
      dout  <= dout_nxt;
    end
  end

`ifdef STACK_ERR_EN
  logic illegal;

  // A replace on an empty stack still counts as an underflow.
  assign illegal = ((op == OP_PUSH)    && full)  ||
                   ((op == OP_POP)     && empty) ||
                   ((op == OP_REPLACE) && empty);

  // Sticky error, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        err <= 1'b0;
    else if (illegal) err <= 1'b1;
  end
`endif

endmodule

// File: doc/stack_mem.md
# stack_mem

Hardware LIFO that stores the data side of the REDUX-V call/data stack, complementing the stack-pointer block: the pointer tracks depth, this block holds and returns the words. The core pushes operands on `push` and reads the top-of-stack from a registered output port. It maintains its own occupancy count, reports full/empty, and refuses illegal operations without corrupting state.

## Interface

- `BITS`, 8, data word width.
- `ADDR_BITS`, 4, log2 of stack depth; depth `DEPTH = 2**ADDR_BITS` entries.

- `clk` input 1 — single clock; all state changes on rising edge.
- `reset` input 1 — asynchronous, active-high; clears all state immediately.
- `push` input 1 — write `din` as new top this cycle.
- `pop` input 1 — remove current top this cycle.
- `din` input BITS — data to push.
- `dout` output BITS — registered top-of-stack word.
- `valid` output 1 — `dout` holds a real entry (stack non-empty).
- `full` output 1 — count == DEPTH.
- `empty` output 1 — count == 0.
- `count` output ADDR_BITS+1 — current occupancy, 0..DEPTH.
- `err` output 1 — sticky illegal-operation flag (only with `STACK_ERR_EN`).

## Operation

- Reset: `count`=0, `dout`=0, `valid`=0, `empty`=1, `full`=0, `err`=0; storage contents undefined.
- Operation decode per cycle: NOP (neither), PUSH, POP, REPLACE (both asserted).
- PUSH, not full: `mem[count]`←`din`, `count`+1, `dout`←`din`.
- PUSH, full: overflow; no state change.
- POP, count ≥ 2: `count`−1, `dout`←`mem[count−2]`.
- POP, count == 1: `count`←0, `dout`←0.
- POP, empty: underflow; no state change.
- REPLACE, count ≥ 1 (including full): `mem[count−1]`←`din`, `dout`←`din`, count unchanged.
- REPLACE, empty: pop portion is underflow; push portion executes as PUSH (count 0→1, `dout`←`din`).
- `full`, `empty`, `valid` are decoded from registered `count`; `valid` = !`empty`.
- Arithmetic: `count` is ADDR_BITS+1 bits, never wraps; memory index is the low ADDR_BITS of the computed address.

## Timing

- All inputs sampled on rising `clk`; `dout`, `count`, flags reflect the operation one cycle later (latency 1).
- Pop-then-push back to back: each cycle independent; no bubbles, one operation per cycle sustained.
- Reset asserted mid-operation: state clears asynchronously; the in-flight operation is discarded; first operation accepted on the first rising edge after `reset` deasserts.
- `dout` is never combinationally driven from `din`.

## Configuration

- `STACK_ERR_EN` defined: `err` port present; set on the cycle after any overflow or underflow, held until `reset`.
- `STACK_ERR_EN` undefined: `err` port absent; illegal operations still ignored exactly as above, silently.

## Structure

- Package `redux_stack_pkg`: `stack_op_t` enum {OP_NOP, OP_PUSH, OP_POP, OP_REPLACE} and the decode function from (`push`,`pop`).
- Sub-module `stack_ram`: DEPTH×BITS array, one synchronous write port, one asynchronous read port (index driven with `count−2` for pop lookahead). The top level holds count, `dout`, flags and error logic.

## Test plan

- Reset, then 3 pushes 0x11,0x22,0x33 -> `count`=3, `dout`=0x33, `valid`=1, `empty`=0.
- From that state, 3 pops -> `dout` sequence 0x22,0x11,0x00; `count` 0; `empty`=1, `valid`=0.
- ADDR_BITS=4: 16 pushes, 17th push 0xAA -> `count` stays 16, `full`=1, `dout` unchanged, `err`=1 (with macro).
- Empty stack, push+pop with `din`=0x5C -> `count`=1, `dout`=0x5C, `err`=1; full stack push+pop 0x77 -> `count` 16, `dout`=0x77, no new error.
- Pop on empty -> no change; `err` rises one cycle later and stays high through further legal ops until `reset`.
- Assert `reset` asynchronously between edges with `count`=5 -> outputs cleared before next edge; push 0x01 after release -> `count`=1, `dout`=0x01.
